// File: rtl/umi_regif_pipe_pkg.sv
// UMI message definitions and command helpers shared by the register bridge.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package umi_regif_pipe_pkg;

  // Request and response opcodes.
  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;

  // Response error codes.
  localparam logic [1:0] UMI_ERR_OK  = 2'b00;
  localparam logic [1:0] UMI_ERR_SLV = 2'b10;
  localparam logic [1:0] UMI_ERR_DEC = 2'b11;

  // 32-bit UMI command word, MSB first.
  typedef struct packed {
    logic [4:0] hostid;
    logic [1:0] err;
    logic       ex;
    logic       eof;
    logic       eom;
    logic [1:0] prot;
    logic [3:0] qos;
    logic [7:0] len;
    logic [2:0] size;
    logic [4:0] opcode;
  } umi_cmd_t;

  typedef struct packed {
    logic is_read;
    logic is_write;
    logic is_posted;
    logic is_atomic;
  } umi_dec_t;

  function automatic umi_cmd_t umi_unpack(input logic [31:0] cmd);
    return umi_cmd_t'(cmd);
  endfunction

  function automatic umi_dec_t umi_decode(input logic [4:0] opcode);
    umi_dec_t d;
    d           = '0;
    d.is_read   = (opcode == UMI_REQ_READ);
    d.is_write  = (opcode == UMI_REQ_WRITE);
    d.is_posted = (opcode == UMI_REQ_POSTED);
    d.is_atomic = (opcode == UMI_REQ_ATOMIC);
    return d;
  endfunction

  // Rebuild a command word from request fields with a new opcode and err.
  function automatic logic [31:0] umi_pack(input umi_cmd_t c, input logic [4:0] opcode,
                                           input logic [1:0] err);
    umi_cmd_t r;
    r        = c;
    r.opcode = opcode;
    r.err    = err;
    return r;
  endfunction

endpackage

// File: rtl/umi_regif_respq.sv
// Synchronous response FIFO, DEPTH entries of WIDTH bits, head shown on rdata.
// Latency: push visible at rdata/!empty the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller bounds occupancy.
//
// Ports: clk/nreset (async active-low), push/wdata, pop, rdata (head), full, empty.
module umi_regif_respq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wptr_d  = wptr_q + {{PW{1'b0}}, do_push};
  assign rptr_d  = rptr_q + {{PW{1'b0}}, do_pop};
  assign rdata   = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/umi_regif_pipe.sv
// Pipelined UMI-to-register bridge: one request per cycle, strobes same cycle, queued responses.
// Latency: response valid RDLAT+1 cycles after accept (reads, writes and error responses alike).
// Backpressure: udev_req_ready drops while DEPTH responses are in flight or queued.
//
// Ports: clk/nreset (async active-low); udev_req_* request in; udev_resp_* response out;
// reg_* register-file strobes, address, unpacked fields, write data; reg_rddata read return.
module umi_regif_pipe
  import umi_regif_pipe_pkg::*;
#(
  parameter int CW        = 32,
  parameter int AW        = 64,
  parameter int DW        = 256,
  parameter int RW        = 64,
  parameter int GRPOFFSET = 24,
  parameter int GRPAW     = 4,
  parameter int GRPID     = 0,
  parameter int RDLAT     = 1,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic [AW-1:0] reg_addr,
  output logic          reg_write,
  output logic          reg_read,
  output logic [4:0]    reg_opcode,
  output logic [2:0]    reg_size,
  output logic [7:0]    reg_len,
  output logic [RW-1:0] reg_wrdata,
  input  logic [RW-1:0] reg_rddata
);

  localparam int NREP = DW / RW;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int QW   = CW + 2 * AW + RW;

  umi_cmd_t    req_cmd;
  umi_dec_t    dec;
  logic        match, ok_size, acc;
  logic [11:0] nbytes;

  logic        rsp, rd_ok, do_rd, do_wr;
  logic [4:0]  rsp_opc;
  logic [1:0]  rsp_err;
  logic [CW-1:0] rsp_cmd;

  assign req_cmd = umi_unpack(udev_req_cmd);
  assign dec     = umi_decode(req_cmd.opcode);
  assign match   = (udev_req_dstaddr[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));
  // Wraps in 12 bits like the legacy block, so very large len/size combinations are not trapped.
  assign nbytes  = ({4'b0, req_cmd.len} + 12'd1) << req_cmd.size;
  assign ok_size = (nbytes <= 12'(RW / 8));
  assign acc     = udev_req_valid & udev_req_ready;

  // Request classification: which strobe fires and what response (if any) is owed.
  always_comb begin
    rsp     = 1'b0;
    rd_ok   = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    rsp_opc = UMI_RESP_READ;
    rsp_err = UMI_ERR_OK;
    if (dec.is_read || dec.is_write) begin
      rsp     = 1'b1;
      rsp_opc = dec.is_read ? UMI_RESP_READ : UMI_RESP_WRITE;
      if (!match) begin
        rsp_err = UMI_ERR_DEC;
      end else if (!ok_size) begin
        rsp_err = UMI_ERR_SLV;
      end else begin
        do_rd = dec.is_read;
        do_wr = dec.is_write;
        rd_ok = dec.is_read;
      end
    end else if (dec.is_atomic) begin
      rsp     = 1'b1;
      rsp_err = UMI_ERR_SLV;
    end else if (dec.is_posted && match && ok_size) begin
      do_wr = 1'b1;
    end
  end

  assign rsp_cmd    = umi_pack(req_cmd, rsp_opc, rsp_err);
  assign reg_read   = acc & do_rd;
  assign reg_write  = acc & do_wr;
  assign reg_addr   = udev_req_dstaddr;
  assign reg_opcode = req_cmd.opcode;
  assign reg_size   = req_cmd.size;
  assign reg_len    = req_cmd.len;
  assign reg_wrdata = udev_req_data[RW-1:0];

  // Response pipe: header travels alongside the register read so data and header line up.
  logic [RDLAT-1:0] pvld_q, prd_q;
  logic [CW-1:0]    pcmd_q [RDLAT];
  logic [AW-1:0]    pdst_q [RDLAT];
  logic [AW-1:0]    psrc_q [RDLAT];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pvld_q <= '0;
      prd_q  <= '0;
      for (int i = 0; i < RDLAT; i++) begin
        pcmd_q[i] <= '0;
        pdst_q[i] <= '0;
        psrc_q[i] <= '0;
      end
    end else begin
      pvld_q[0] <= acc & rsp;
      prd_q[0]  <= acc & rd_ok;
      if (acc & rsp) begin
        pcmd_q[0] <= rsp_cmd;
        pdst_q[0] <= udev_req_srcaddr;
        psrc_q[0] <= udev_req_dstaddr;
      end
      for (int i = 1; i < RDLAT; i++) begin
        pvld_q[i] <= pvld_q[i-1];
        prd_q[i]  <= prd_q[i-1];
        pcmd_q[i] <= pcmd_q[i-1];
        pdst_q[i] <= pdst_q[i-1];
        psrc_q[i] <= psrc_q[i-1];
      end
    end
  end

  logic          q_push, q_pop, q_full, q_empty;
  logic [QW-1:0] q_wdata, q_rdata, q_head;
  logic [RW-1:0] resp_rd;

  assign q_push  = pvld_q[RDLAT-1];
  assign q_wdata = {pcmd_q[RDLAT-1], pdst_q[RDLAT-1], psrc_q[RDLAT-1],
                    prd_q[RDLAT-1] ? reg_rddata : {RW{1'b0}}};
  assign q_pop   = udev_resp_valid & udev_resp_ready;

  umi_regif_respq #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_respq (
    .clk    (clk),
    .nreset (nreset),
    .push   (q_push),
    .wdata  (q_wdata),
    .pop    (q_pop),
    .rdata  (q_rdata),
    .full   (q_full),
    .empty  (q_empty)
  );

  // Outputs read as zero while nothing is queued, so stale entries never leak out.
  assign q_head          = q_empty ? {QW{1'b0}} : q_rdata;
  assign udev_resp_valid = ~q_empty;
  assign {udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, resp_rd} = q_head;
  assign udev_resp_data  = {NREP{resp_rd}};

  // Credit counts responses in the pipe plus in the queue, so the queue can never overflow.
  logic [CNTW-1:0] credit_q, credit_d;
  logic            cr_inc;

  assign cr_inc         = acc & rsp;
  assign udev_req_ready = (credit_q < CNTW'(DEPTH));

  always_comb begin
    credit_d = credit_q;
    if (cr_inc && !q_pop) begin
      credit_d = credit_q + CNTW'(1);
    end else if (q_pop && !cr_inc) begin
      credit_d = credit_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  // Upper request data bits and the full flag are intentionally not consumed.
  logic unused_ok;
  assign unused_ok = ^{udev_req_data, q_full};

endmodule
